modbus_tx_buffer: RTL and testbench
===================================

// Module: modbus_tx_buffer
// PURPOSE
//  Response-side buffer for the Modbus RTU slave: accepts response bytes from the
//  Modbus-to-Wishbone engine over its req/ack FIFO write port and feeds a UART
//  transmitter one byte at a time. Holds bytes until a frame is ready, so the UART
//  does not underrun mid-frame, and enforces an inter-frame silence after each frame.
// PARAMETERS
//  DEPTH        256  buffer entries; power of 2; >= largest RTU frame (256 B)
//  START_LEVEL  8    buffered byte count that starts transmission immediately
//  IDLE_CYCLES  64   writer-idle fifoClk cycles that start transmission of a partial frame
//  GAP_CYCLES   400  silence cycles after last byte done (>= 3.5 char times at fifoClk)
// PORTS
//  fifoClk      in   1   clock; everything on posedge
//  rst          in   1   synchronous, active-high reset
//  writeReq     in   1   writer holds high with dataIn valid until writeAck seen
//  dataIn       in   8   byte to store
//  writeAck     out  1   one-cycle pulse: byte accepted
//  full         out  1   level == DEPTH
//  level        out  $clog2(DEPTH)+1  bytes currently stored
//  txData       out  8   byte for UART transmitter, valid while txStart high
//  txStart      out  1   one-cycle pulse: UART loads txData
//  txBusy       in   1   UART shifting a character
//  frameActive  out  1   high from first txStart of a frame until GAP state ends
// BEHAVIOUR
//  Reset: writeAck=0, full=0, level=0, txData=0, txStart=0, frameActive=0, pointers=0,
//   idle/gap counters=0, FSM=IDLE. Applies mid-frame; buffered bytes are discarded.
//  Write: on edge with writeReq=1, writeAck=0, level<DEPTH: mem[wrPtr]<=dataIn,
//   wrPtr++, writeAck<=1 (next cycle). writeAck is never high two cycles in a row;
//   req still high while ack high is not a new write. Full: req is held, no ack.
//  Pointers wrap modulo DEPTH; full/empty from level, not from pointer compare.
//  Same-edge write and read: level unchanged; both pointers advance.
//  Idle counter: cleared on every accepted write, else saturates at IDLE_CYCLES.
//  FSM:
//   IDLE:  if level>0 and (level>=START_LEVEL or idleCnt==IDLE_CYCLES):
//          txData<=mem[rdPtr], txStart<=1, rdPtr++, frameActive<=1 -> WAIT_BUSY.
//   WAIT_BUSY: txBusy=1 -> WAIT_DONE (txStart already back to 0).
//   WAIT_DONE: txBusy=0: level>0 -> issue next byte as in IDLE (no threshold) ->
//          WAIT_BUSY; level==0 -> gapCnt<=0 -> GAP.
//   GAP:   gapCnt++; at GAP_CYCLES-1: frameActive<=0 -> IDLE. Writes still accepted.
//  txStart latency: 1 cycle after start condition; max one byte outstanding.
//  Bytes arriving during WAIT_* extend the current frame (no gap in between).
// TESTING
//  1 reset, write 8 bytes 37 10 00 05 00 02 41 9B with ack after each -> 8 txStart
//    pulses, txData in same order, frameActive falls GAP_CYCLES after last txBusy fall.
//  2 write 3 bytes 37 83 02, stop -> no txStart for IDLE_CYCLES, then 3 bytes sent.
//  3 fill DEPTH bytes with txBusy stuck 1 -> full=1, level=256, next writeReq gets
//    no ack until a byte is read; wrPtr wraps, data order intact.
//  4 writeReq held high 5 cycles -> writeAck pattern 0,1,0,1,0; exactly 2 bytes stored.
//  5 write during GAP -> byte buffered, not sent before gap expires.
//  6 rst asserted in WAIT_DONE with level=5 -> next cycle level=0, txStart=0,
//    frameActive=0, FSM IDLE; later writes behave as after power-up.

Source files
------------

// File: rtl/modbus_tx_buffer.sv
// Response-side byte buffer between the Modbus-to-Wishbone engine and the UART transmitter.
// Releases a frame once enough bytes are queued (or the writer goes quiet) and enforces inter-frame silence.
module modbus_tx_buffer #(
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned START_LEVEL = 8,
    parameter int unsigned IDLE_CYCLES = 64,
    parameter int unsigned GAP_CYCLES  = 400
) (
    input  logic                     fifoClk,
    input  logic                     rst,
    input  logic                     writeReq,
    input  logic [7:0]               dataIn,
    output logic                     writeAck,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               txData,
    output logic                     txStart,
    input  logic                     txBusy,
    output logic                     frameActive
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned IW = $clog2(IDLE_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUSY,
        S_WAIT_DONE,
        S_GAP
    } state_t;

    state_t          state_q;
    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [LW-1:0]   level_q;
    logic [LW-1:0]   level_d;
    logic [IW-1:0]   idle_cnt_q;
    logic [GW-1:0]   gap_cnt_q;
    logic            ack_q;
    logic            full_q;
    logic [7:0]      tx_data_q;
    logic            tx_start_q;
    logic            frame_q;
    logic            wr_en_c;
    logic            rd_en_c;
    logic            can_start_c;

    // A held request is only a new write once the previous ack has been seen.
    assign wr_en_c     = writeReq && !ack_q && (level_q != LW'(DEPTH));
    assign can_start_c = (level_q != '0) &&
                         ((level_q >= LW'(START_LEVEL)) || (idle_cnt_q == IW'(IDLE_CYCLES)));
    assign level_d     = level_q + LW'(wr_en_c) - LW'(rd_en_c);

    // Byte pulled from the buffer towards the UART this cycle.
    always_comb begin
        rd_en_c = 1'b0;
        case (state_q)
            S_IDLE:      rd_en_c = can_start_c;
            S_WAIT_DONE: rd_en_c = !txBusy && (level_q != '0);
            default:     rd_en_c = 1'b0;
        endcase
    end

    // Storage array carries no reset; validity is tracked by the level count.
    always_ff @(posedge fifoClk) begin
        if (wr_en_c) begin
            mem_q[wr_ptr_q] <= dataIn;
        end
    end

    always_ff @(posedge fifoClk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            idle_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ack_q      <= 1'b0;
            full_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            ack_q      <= wr_en_c;
            level_q    <= level_d;
            full_q     <= (level_d == LW'(DEPTH));
            tx_start_q <= 1'b0;

            if (wr_en_c) begin
                wr_ptr_q   <= wr_ptr_q + AW'(1);
                idle_cnt_q <= '0;
            end else if (idle_cnt_q != IW'(IDLE_CYCLES)) begin
                idle_cnt_q <= idle_cnt_q + IW'(1);
            end

            if (rd_en_c) begin
                tx_data_q  <= mem_q[rd_ptr_q];
                tx_start_q <= 1'b1;
                rd_ptr_q   <= rd_ptr_q + AW'(1);
            end

            // Frame sequencing: one byte outstanding at a time, silence after the last one.
            case (state_q)
                S_IDLE: begin
                    if (rd_en_c) begin
                        frame_q <= 1'b1;
                        state_q <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    if (txBusy) begin
                        state_q <= S_WAIT_DONE;
                    end
                end
                S_WAIT_DONE: begin
                    if (!txBusy) begin
                        if (rd_en_c) begin
                            state_q <= S_WAIT_BUSY;
                        end else begin
                            gap_cnt_q <= '0;
                            state_q   <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt_q == GW'(GAP_CYCLES - 1)) begin
                        frame_q <= 1'b0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_cnt_q <= gap_cnt_q + GW'(1);
                    end
                end
            endcase
        end
    end

    assign writeAck    = ack_q;
    assign full        = full_q;
    assign level       = level_q;
    assign txData      = tx_data_q;
    assign txStart     = tx_start_q;
    assign frameActive = frame_q;

endmodule

// File: tb/tb_modbus_tx_buffer.sv
// Bench for modbus_tx_buffer: directed scenarios plus random traffic, every cycle
// compared against a queue-based model of the buffer and frame timing.
module tb_modbus_tx_buffer;

    localparam int unsigned DEPTH       = 256;
    localparam int unsigned START_LEVEL = 8;
    localparam int unsigned IDLE_CYCLES = 64;
    localparam int unsigned GAP_CYCLES  = 400;

    logic        fifoClk = 1'b0;
    logic        rst;
    logic        writeReq;
    logic [7:0]  dataIn;
    logic        writeAck;
    logic        full;
    logic [8:0]  level;
    logic [7:0]  txData;
    logic        txStart;
    logic        txBusy = 1'b0;
    logic        frameActive;

    modbus_tx_buffer #(
        .DEPTH(DEPTH), .START_LEVEL(START_LEVEL),
        .IDLE_CYCLES(IDLE_CYCLES), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .fifoClk(fifoClk), .rst(rst), .writeReq(writeReq), .dataIn(dataIn),
        .writeAck(writeAck), .full(full), .level(level), .txData(txData),
        .txStart(txStart), .txBusy(txBusy), .frameActive(frameActive)
    );

    always #5 fifoClk = ~fifoClk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    bit chk_en = 0;
    logic [7:0] tx_log [$];

    always @(posedge fifoClk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural model: a byte queue plus "frame open / byte owed / gap remaining" bookkeeping.
    byte unsigned mq [$];
    bit         m_ack, m_start, m_frame, m_owed;
    int         m_idle, m_gap;
    logic [7:0] m_data;

    always @(posedge fifoClk) begin
        int lvl;
        bit acc, issue;
        if (rst) begin
            mq.delete();
            m_ack = 0; m_start = 0; m_frame = 0; m_owed = 0;
            m_idle = 0; m_gap = 0; m_data = 8'h00;
        end else begin
            lvl   = mq.size();
            acc   = writeReq && !m_ack && (lvl < DEPTH);
            issue = 0;
            if (!m_frame) begin
                if (lvl > 0 && (lvl >= START_LEVEL || m_idle == IDLE_CYCLES)) begin
                    issue = 1; m_frame = 1;
                end
            end else if (m_owed) begin
                if (txBusy) m_owed = 0;
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) m_frame = 0;
            end else if (!txBusy) begin
                if (lvl > 0) issue = 1;
                else m_gap = GAP_CYCLES;
            end
            if (issue) begin
                m_data = mq.pop_front();
                m_owed = 1;
            end
            m_start = issue;
            if (acc) mq.push_back(dataIn);
            m_ack  = acc;
            m_idle = acc ? 0 : ((m_idle < IDLE_CYCLES) ? m_idle + 1 : m_idle);
        end
    end

    // Single compare process, away from the active edge.
    always @(negedge fifoClk) begin
        if (chk_en) begin
            chk("writeAck", writeAck, m_ack);
            chk("level", level, mq.size());
            chk("full", full, mq.size() == DEPTH);
            chk("txStart", txStart, m_start);
            chk("txData", txData, m_data);
            chk("frameActive", frameActive, m_frame);
            if (txStart) tx_log.push_back(txData);
        end
    end

    // UART stand-in: busy rises a little after txStart, holds a few cycles, or can be pinned high.
    bit force_busy = 0;
    bit u_pend = 0;
    int u_delay = 0, u_hold = 0, last_fall = 0;

    always @(negedge fifoClk) begin
        if (force_busy) begin
            txBusy = 1'b1; u_pend = 0; u_hold = 0;
        end else if (txStart) begin
            u_pend = 1; u_delay = $urandom_range(0, 2);
        end else if (u_pend) begin
            if (u_delay == 0) begin
                u_pend = 0; txBusy = 1'b1; u_hold = $urandom_range(1, 5);
            end else u_delay--;
        end else if (txBusy) begin
            if (u_hold == 0) begin
                txBusy = 1'b0; last_fall = cyc;
            end else u_hold--;
        end
    end

    task automatic write_byte(input logic [7:0] b);
        int n = 0;
        writeReq = 1'b1;
        dataIn   = b;
        do begin
            @(negedge fifoClk);
            n++;
        end while (!writeAck && n < 2000);
        if (!writeAck) chk("write_ack_timeout", 32'd0, 32'd1);
        writeReq = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((frameActive || level != 0 || txStart || writeAck) && n < 10000) begin
            @(negedge fifoClk);
            n++;
        end
        chk("wait_idle_timeout", n < 10000, 1);
        repeat (3) @(negedge fifoClk);
    endtask

    task automatic wait_frame_fall();
        int n = 0;
        while (!frameActive && n < 500) begin @(negedge fifoClk); n++; end
        chk("frame_rise_timeout", frameActive, 1);
        n = 0;
        while (frameActive && n < 5000) begin @(negedge fifoClk); n++; end
        chk("frame_fall_timeout", frameActive, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] t1 [8] = '{8'h37, 8'h10, 8'h00, 8'h05, 8'h00, 8'h02, 8'h41, 8'h9B};
        logic [7:0] t2 [3] = '{8'h37, 8'h83, 8'h02};
        logic       t4 [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [7:0] wq [$];
        int base, t_ack, n, cnt;

        rst = 1'b1; writeReq = 1'b0; dataIn = 8'h00;
        @(negedge fifoClk);
        chk_en = 1;
        @(negedge fifoClk);
        chk("rst_level", level, 0);
        chk("rst_full", full, 0);
        chk("rst_ack", writeAck, 0);
        chk("rst_txStart", txStart, 0);
        chk("rst_txData", txData, 0);
        chk("rst_frame", frameActive, 0);
        rst = 1'b0;
        @(negedge fifoClk);

        // 1: eight-byte frame released by the start level
        base = tx_log.size();
        foreach (t1[i]) write_byte(t1[i]);
        wait_frame_fall();
        // busy drops between edges; the edge that sees it opens a GAP_CYCLES-edge silence
        chk("t1_gap_len", cyc - last_fall, GAP_CYCLES + 1);
        chk("t1_count", tx_log.size() - base, 8);
        for (int i = 0; i < 8; i++)
            if (base + i < tx_log.size()) chk("t1_data", tx_log[base + i], t1[i]);
        wait_idle();

        // 2: short frame released only by writer idle timeout
        base = tx_log.size();
        foreach (t2[i]) write_byte(t2[i]);
        t_ack = cyc;
        n = 0;
        while (!txStart && n < 500) begin @(negedge fifoClk); n++; end
        chk("t2_latency", cyc - t_ack, IDLE_CYCLES + 1);
        wait_frame_fall();
        chk("t2_count", tx_log.size() - base, 3);
        for (int i = 0; i < 3; i++)
            if (base + i < tx_log.size()) chk("t2_data", tx_log[base + i], t2[i]);
        wait_idle();

        // 3: fill to DEPTH with the UART stuck busy, then drain across the pointer wrap
        base = tx_log.size();
        force_busy = 1;
        @(negedge fifoClk);
        for (int i = 0; i < 300 && level != DEPTH; i++) begin
            wq.push_back(8'($urandom));
            write_byte(wq[wq.size() - 1]);
        end
        chk("t3_full", full, 1);
        chk("t3_level", level, 256);
        writeReq = 1'b1; dataIn = 8'hC3; wq.push_back(8'hC3);
        repeat (10) begin
            @(negedge fifoClk);
            chk("t3_no_ack_when_full", writeAck, 0);
        end
        force_busy = 0;
        n = 0;
        while (!writeAck && n < 200) begin @(negedge fifoClk); n++; end
        chk("t3_ack_after_read", writeAck, 1);
        writeReq = 1'b0;
        wait_idle();
        chk("t3_count", tx_log.size() - base, wq.size());
        for (int i = 0; i < wq.size(); i++)
            if (base + i < tx_log.size()) chk("t3_order", tx_log[base + i], wq[i]);

        // 4: request held across several edges
        writeReq = 1'b1; dataIn = 8'hA1;
        for (int i = 0; i < 5; i++) begin
            chk("t4_ack_pattern", writeAck, t4[i]);
            if (i == 2) dataIn = 8'hA2;
            if (i < 4) @(negedge fifoClk);
        end
        writeReq = 1'b0;
        chk("t4_level", level, 2);

        // 5: byte written during the gap waits for the gap to expire
        base = tx_log.size();
        n = 0;
        while (!frameActive && n < 500) begin @(negedge fifoClk); n++; end
        repeat (60) @(negedge fifoClk);
        write_byte(8'h5A);
        cnt = 0; n = 0;
        while (frameActive && n < 1000) begin
            if (txStart) cnt++;
            @(negedge fifoClk); n++;
        end
        chk("t5_no_tx_in_gap", cnt, 0);
        chk("t5_pre_count", tx_log.size() - base, 2);
        n = 0;
        while (!txStart && n < 200) begin @(negedge fifoClk); n++; end
        chk("t5_data", txData, 8'h5A);
        wait_idle();

        // 6: reset while waiting on the UART with bytes still queued
        force_busy = 1;
        for (int i = 0; i < 6; i++) write_byte(8'($urandom));
        n = 0;
        while (!frameActive && n < 500) begin @(negedge fifoClk); n++; end
        repeat (3) @(negedge fifoClk);
        chk("t6_pre_level", level, 5);
        rst = 1'b1;
        @(negedge fifoClk);
        rst = 1'b0;
        chk("t6_level", level, 0);
        chk("t6_txStart", txStart, 0);
        chk("t6_frame", frameActive, 0);
        chk("t6_full", full, 0);
        force_busy = 0;
        repeat (3) @(negedge fifoClk);
        base = tx_log.size();
        for (int i = 0; i < 8; i++) write_byte(8'($urandom));
        wait_idle();
        chk("t6_after_count", tx_log.size() - base, 8);

        // Random traffic: bursts with random spacing and occasional long pauses
        for (int f = 0; f < 20; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                write_byte(8'($urandom));
                repeat ($urandom_range(0, 3)) @(negedge fifoClk);
                if ($urandom_range(0, 15) == 0) repeat ($urandom_range(40, 90)) @(negedge fifoClk);
            end
            if ($urandom_range(0, 1) == 0) wait_idle();
        end
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
